// File: rtl/arbitro_rr_mux_pkg.sv
// Shared types, sizes and the round-robin search used by the arbiter.
package arbitro_rr_mux_pkg;

  localparam int unsigned ANCHO_DATOS_DEF = 4;
  localparam int unsigned N_CANALES       = 4;
  localparam int unsigned ANCHO_SEL       = 2;
  localparam int unsigned ANCHO_CONT      = 4;

  typedef enum logic {
    LIBRE     = 1'b0,
    CONCEDIDO = 1'b1
  } estado_t;

  // First set request bit strictly after ptr, wrapping modulo four.
  function automatic logic [ANCHO_SEL-1:0] ganador_rr(
    input logic [N_CANALES-1:0] sol,
    input logic [ANCHO_SEL-1:0] ptr
  );
    logic [ANCHO_SEL-1:0] res;
    logic [ANCHO_SEL-1:0] idx;
    logic                 hallado;
    res     = '0;
    hallado = 1'b0;
    for (int unsigned k = 1; k <= N_CANALES; k++) begin
      idx = ptr + ANCHO_SEL'(k);
      if (!hallado && sol[idx]) begin
        res     = idx;
        hallado = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arbitro_rr_mux_if.sv
// Producer/consumer side bundle of the arbiter: requests, data, handshake and grant.
interface arbitro_rr_mux_if
  import arbitro_rr_mux_pkg::*;
#(
  parameter int unsigned ANCHO_DATOS = ANCHO_DATOS_DEF
);

  logic [N_CANALES-1:0]   i_Solicitud;
  logic [ANCHO_DATOS-1:0] i_Datos_0;
  logic [ANCHO_DATOS-1:0] i_Datos_1;
  logic [ANCHO_DATOS-1:0] i_Datos_2;
  logic [ANCHO_DATOS-1:0] i_Datos_3;
  logic                   i_Listo;
  logic [N_CANALES-1:0]   o_Concesion;
  logic [ANCHO_SEL-1:0]   o_Sel;
  logic [ANCHO_DATOS-1:0] o_Salida;
  logic                   o_Valido;
  logic                   o_Ocupado;

  // Producers and downstream consumer side.
  modport master (
    output i_Solicitud, i_Datos_0, i_Datos_1, i_Datos_2, i_Datos_3, i_Listo,
    input  o_Concesion, o_Sel, o_Salida, o_Valido, o_Ocupado
  );

  // Arbiter side.
  modport slave (
    input  i_Solicitud, i_Datos_0, i_Datos_1, i_Datos_2, i_Datos_3, i_Listo,
    output o_Concesion, o_Sel, o_Salida, o_Valido, o_Ocupado
  );

endinterface

// File: rtl/arbitro_rr_mux_selector_4a1.sv
// Combinational 4:1 data selector driven by the arbiter's select.
module selector_4a1
  import arbitro_rr_mux_pkg::*;
#(
  parameter int unsigned ANCHO = ANCHO_DATOS_DEF
) (
  input  logic [ANCHO_SEL-1:0] i_sel,
  input  logic [ANCHO-1:0]     i_d0,
  input  logic [ANCHO-1:0]     i_d1,
  input  logic [ANCHO-1:0]     i_d2,
  input  logic [ANCHO-1:0]     i_d3,
  output logic [ANCHO-1:0]     o_y
);

  // Pick the channel named by i_sel.
  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/arbitro_rr_mux.sv
// Round-robin arbiter for four requesters with burst limit, steering one 4:1 selector.
module arbitro_rr_mux
  import arbitro_rr_mux_pkg::*;
#(
  parameter int unsigned ANCHO_DATOS = ANCHO_DATOS_DEF,
  parameter int unsigned MAX_RAFAGA  = 4
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  arbitro_rr_mux_if.slave bus
);

  localparam logic [ANCHO_CONT-1:0] ULTIMO_BEAT = ANCHO_CONT'(MAX_RAFAGA - 1);

  estado_t                state_q, state_d;
  logic [ANCHO_SEL-1:0]   sel_q, sel_d;
  logic [N_CANALES-1:0]   conc_q, conc_d;
  logic [ANCHO_CONT-1:0]  cont_q, cont_d;
  logic [ANCHO_SEL-1:0]   ptr_q, ptr_d;
  logic [ANCHO_SEL-1:0]   ganador;
  logic                   valido_c;
  logic [ANCHO_DATOS-1:0] mux_y;

  selector_4a1 #(.ANCHO(ANCHO_DATOS)) u_selector (
    .i_sel (sel_q),
    .i_d0  (bus.i_Datos_0),
    .i_d1  (bus.i_Datos_1),
    .i_d2  (bus.i_Datos_2),
    .i_d3  (bus.i_Datos_3),
    .o_y   (mux_y)
  );

  // State and datapath registers; pointer resets to 3 so the first search starts at channel 0.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= LIBRE;
      sel_q   <= '0;
      conc_q  <= '0;
      cont_q  <= '0;
      ptr_q   <= ANCHO_SEL'(3);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      conc_q  <= conc_d;
      cont_q  <= cont_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: grant from LIBRE, count beats and release on burst end or request drop.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    conc_d  = conc_q;
    cont_d  = cont_q;
    ptr_d   = ptr_q;
    ganador = ganador_rr(bus.i_Solicitud, ptr_q);
    case (state_q)
      LIBRE: begin
        if (bus.i_Solicitud != '0) begin
          sel_d   = ganador;
          conc_d  = N_CANALES'(1) << ganador;
          cont_d  = '0;
          state_d = CONCEDIDO;
        end
      end
      CONCEDIDO: begin
        if (!bus.i_Solicitud[sel_q] || (bus.i_Listo && (cont_q == ULTIMO_BEAT))) begin
          ptr_d   = sel_q;
          conc_d  = '0;
          cont_d  = '0;
          state_d = LIBRE;
        end else if (bus.i_Listo) begin
          cont_d = cont_q + ANCHO_CONT'(1);
        end
      end
      default: state_d = LIBRE;
    endcase
  end

  // Outputs: valid follows the granted request live; data is gated to zero when not valid.
  always_comb begin
    valido_c = 1'b0;
    if (state_q == CONCEDIDO) begin
      valido_c = bus.i_Solicitud[sel_q];
    end
    bus.o_Valido  = valido_c;
    bus.o_Salida  = valido_c ? mux_y : '0;
    bus.o_Ocupado = (state_q == CONCEDIDO);
  end

  assign bus.o_Concesion = conc_q;
  assign bus.o_Sel       = sel_q;

endmodule

// File: tb/tb_arbitro_rr_mux.sv
// Directed and random checks of arbitro_rr_mux against a turn-based reference model.
module tb_arbitro_rr_mux;

  localparam int unsigned AD = 4;
  localparam int MR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    sol;
  logic          listo;
  logic [AD-1:0] datos [4];

  arbitro_rr_mux_if #(.ANCHO_DATOS(AD)) bus ();

  assign bus.i_Solicitud = sol;
  assign bus.i_Listo     = listo;
  assign bus.i_Datos_0   = datos[0];
  assign bus.i_Datos_1   = datos[1];
  assign bus.i_Datos_2   = datos[2];
  assign bus.i_Datos_3   = datos[3];

  arbitro_rr_mux #(.ANCHO_DATOS(AD), .MAX_RAFAGA(MR)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the channel, beats served this turn, last winner.
  int   owner;
  int   ptr;
  int   last_sel;
  int   beats;
  int   mdl_beats [4];
  int   dut_beats [4];
  int   grant_log [$];
  logic prev_ocup;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner    = -1;
    ptr      = 3;
    last_sel = 0;
    beats    = 0;
  endtask

  task automatic check_outputs();
    int e_conc, e_sel, e_val, e_sal, e_ocu;
    if (owner >= 0) begin
      e_conc = 1 << owner;
      e_sel  = owner;
      e_ocu  = 1;
      e_val  = int'(sol[owner]);
      e_sal  = (e_val == 1) ? int'(datos[owner]) : 0;
    end else begin
      e_conc = 0;
      e_sel  = last_sel;
      e_ocu  = 0;
      e_val  = 0;
      e_sal  = 0;
    end
    chk("concesion", 32'(bus.o_Concesion), 32'(e_conc));
    chk("sel",       32'(bus.o_Sel),       32'(e_sel));
    chk("valido",    32'(bus.o_Valido),    32'(e_val));
    chk("salida",    32'(bus.o_Salida),    32'(e_sal));
    chk("ocupado",   32'(bus.o_Ocupado),   32'(e_ocu));
  endtask

  // Advance the model by one rising edge using the inputs held across it.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (owner < 0) begin
      if (sol != 4'b0000) begin
        for (int i = 1; i <= 4; i++) begin
          if (owner < 0 && sol[(ptr + i) % 4]) owner = (ptr + i) % 4;
        end
        last_sel = owner;
        beats    = 0;
      end
    end else if (!sol[owner]) begin
      ptr   = owner;
      owner = -1;
      beats = 0;
    end else if (listo) begin
      mdl_beats[owner]++;
      beats++;
      if (beats == MR) begin
        ptr   = owner;
        owner = -1;
        beats = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (bus.o_Ocupado === 1'b1 && prev_ocup !== 1'b1) grant_log.push_back(int'(bus.o_Sel));
    prev_ocup = bus.o_Ocupado;
    if (!rst && bus.o_Valido === 1'b1 && listo) dut_beats[bus.o_Sel]++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic l);
    sol   = s;
    listo = l;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) begin
      dut_beats[c] = 0;
      mdl_beats[c] = 0;
    end
    grant_log.delete();
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b0000, 1'b0);
    for (int c = 0; c < 4; c++) datos[c] = AD'($urandom);
    prev_ocup = 1'b0;
    model_reset();
    clear_counts();

    // Reset state.
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Single requester on channel 2.
    datos[2] = 4'hA;
    clear_counts();
    drive(4'b0100, 1'b1);
    repeat (5) cycle();
    chk("sr_beats", 32'(dut_beats[2]), 32'd4);
    chk("sr_bubble_conc", 32'(bus.o_Concesion), 32'h0);
    chk("sr_bubble_sel", 32'(bus.o_Sel), 32'd2);
    cycle();
    chk("sr_regrant", 32'(bus.o_Concesion), 32'b0100);
    drive(4'b0000, 1'b1);
    repeat (2) cycle();

    // All four requesting from a fresh reset: order 0,1,2,3,0,... and equal shares.
    rst = 1'b1;
    model_reset();
    cycle();
    rst = 1'b0;
    clear_counts();
    drive(4'b1111, 1'b1);
    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < 4; c++) datos[c] = AD'($urandom);
      cycle();
    end
    for (int c = 0; c < 4; c++) chk("all4_beats", 32'(dut_beats[c]), 32'd8);
    chk("all4_ngrants", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_log.size()) chk("all4_order", 32'(grant_log[i]), 32'(i % 4));
    end
    drive(4'b0000, 1'b1);
    cycle();

    // Backpressure on channel 3 after the second beat.
    datos[3] = 4'h5;
    clear_counts();
    drive(4'b1000, 1'b1);
    repeat (3) cycle();
    drive(4'b1000, 1'b0);
    repeat (3) begin
      cycle();
      chk("bp_valido", 32'(bus.o_Valido), 32'd1);
      chk("bp_conc", 32'(bus.o_Concesion), 32'b1000);
    end
    drive(4'b1000, 1'b1);
    repeat (2) cycle();
    chk("bp_beats", 32'(dut_beats[3]), 32'd4);
    chk("bp_release", 32'(bus.o_Concesion), 32'h0);

    // Pointer wrap: after channel 3, requests on 3 and 0 go to 0.
    drive(4'b1001, 1'b1);
    cycle();
    chk("wrap_ch0", 32'(bus.o_Concesion), 32'b0001);
    drive(4'b0000, 1'b1);
    repeat (2) cycle();

    // Early drop on channel 1 while channel 0 waits.
    drive(4'b0010, 1'b1);
    cycle();
    clear_counts();
    drive(4'b0011, 1'b1);
    repeat (2) cycle();
    drive(4'b0001, 1'b1);
    cycle();
    chk("ed_release", 32'(bus.o_Concesion), 32'h0);
    chk("ed_beats1", 32'(dut_beats[1]), 32'd2);
    chk("ed_beats0", 32'(dut_beats[0]), 32'd0);
    cycle();
    chk("ed_grant0", 32'(bus.o_Concesion), 32'b0001);
    drive(4'b0000, 1'b1);
    repeat (2) cycle();

    // Reset in the middle of a channel 1 burst.
    drive(4'b0010, 1'b1);
    repeat (2) cycle();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_conc", 32'(bus.o_Concesion), 32'h0);
    chk("rst_sel", 32'(bus.o_Sel), 32'h0);
    chk("rst_valido", 32'(bus.o_Valido), 32'h0);
    chk("rst_salida", 32'(bus.o_Salida), 32'h0);
    chk("rst_ocupado", 32'(bus.o_Ocupado), 32'h0);
    cycle();
    rst = 1'b0;
    repeat (2) cycle();
    chk("rst_regrant", 32'(bus.o_Concesion), 32'b0010);
    drive(4'b0000, 1'b1);
    repeat (2) cycle();

    // Random traffic with occasional reset.
    clear_counts();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) sol = 4'($urandom);
      listo = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) datos[c] = AD'($urandom);
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      cycle();
    end
    for (int c = 0; c < 4; c++) chk("rand_beats", 32'(dut_beats[c]), 32'(mdl_beats[c]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
